// File: rtl/movavg.sv
// movavg -- 4-tap moving-sum pre-filter for a 64-bit unsigned sample stream.
//
// Each cycle dout is the sum of the current input sample and the NTAPS-1
// previous samples, truncated to WL bits. The output is combinational, so
// latency is zero. The block does not divide; a consumer that wants the
// mean shifts right by log2(NTAPS) downstream.
//
// Ports
//   clk    in   1    rising-edge clock
//   reset  in   1    synchronous, active-high; clears the delay line
//   din    in   WL   input sample, consumed on every clock edge
//   dout   out  WL   din + tap1 + ... + tap(NTAPS-1), modulo 2^WL
module movavg #(
    parameter int WL    = 64,
    parameter int NTAPS = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [WL-1:0] din,
    output logic [WL-1:0] dout
);

    generate
        if (NTAPS > 1) begin : g_taps
            // r_tap[0] is the most recent past sample (tap1).
            logic [WL-1:0] r_tap [NTAPS-1];
            logic [WL-1:0] w_sum;

            // din is deliberately not captured on a reset edge, so the
            // first post-reset cycle sees an empty window.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < NTAPS - 1; i++) begin
                        r_tap[i] <= '0;
                    end
                end else begin
                    r_tap[0] <= din;
                    for (int i = 1; i < NTAPS - 1; i++) begin
                        r_tap[i] <= r_tap[i-1];
                    end
                end
            end

            // Carries beyond bit WL-1 are dropped, giving modulo-2^WL wrap.
            always_comb begin
                w_sum = din;
                for (int i = 0; i < NTAPS - 1; i++) begin
                    w_sum = w_sum + r_tap[i];
                end
            end

            assign dout = w_sum;
        end else begin : g_passthru
            assign dout = din;
        end
    endgenerate

endmodule

// File: tb/tb_movavg.sv
module tb_movavg;

    logic        clk;
    logic        reset;
    logic [63:0] din;
    logic [63:0] dout;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb [$];
    logic [63:0] h1, h2, h3;

    movavg #(.WL(64), .NTAPS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference delay line, driven only from the bench's own stimulus.
    always @(posedge clk) begin
        if (reset) begin
            h1 <= '0;
            h2 <= '0;
            h3 <= '0;
        end else begin
            h3 <= h2;
            h2 <= h1;
            h1 <= din;
        end
    end

    function automatic logic [63:0] model_sum(input logic [63:0] d);
        return d + h1 + h2 + h3;
    endfunction

    // Inputs change 1 unit after the rising edge; dout is sampled 1 unit
    // before the next rising edge.
    task automatic test_reset();
        logic [63:0] d [2] = '{64'h0, 64'hABC};
        logic [63:0] got, exp;
        for (int i = 0; i < 2; i++) begin
            reset = 1'b1;
            din   = d[i];
            sb.push_back(d[i]);
            #8;
            got = dout;
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset[%0d]: got %h expected %h", i, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ramp();
        logic [63:0] d [6] = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd4, 64'd5};
        logic [63:0] e [6] = '{64'd0, 64'd1, 64'd3, 64'd6, 64'd10, 64'd14};
        logic [63:0] got, exp;
        for (int i = 0; i < 6; i++) begin
            reset = (i == 0);
            din   = d[i];
            sb.push_back(e[i]);
            #8;
            got = dout;
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ramp[%0d]: got %h expected %h", i, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        logic [63:0] e [6] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE,
                               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFC,
                               64'hFFFF_FFFF_FFFF_FFFC};
        logic [63:0] got, exp;
        for (int i = 0; i < 6; i++) begin
            reset = (i == 0);
            din   = (i == 0) ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF;
            sb.push_back((i == 0) ? model_sum(din) : e[i]);
            #8;
            got = dout;
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wrap[%0d]: got %h expected %h", i, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mid_reset();
        logic        r [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [63:0] d [7] = '{64'd0, 64'd10, 64'd20, 64'd30, 64'd40, 64'd7, 64'd8};
        logic [63:0] e [7] = '{64'd0, 64'd10, 64'd30, 64'd60, 64'd100, 64'd7, 64'd15};
        logic [63:0] got, exp;
        for (int i = 0; i < 7; i++) begin
            reset = r[i];
            din   = d[i];
            sb.push_back((i == 0) ? model_sum(din) : e[i]);
            #8;
            got = dout;
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_reset[%0d]: got %h expected %h", i, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_step();
        logic [63:0] d [9] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h100, 64'h100,
                               64'h100, 64'h100, 64'h100};
        logic [63:0] e [9] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h100, 64'h200,
                               64'h300, 64'h400, 64'h400};
        logic [63:0] got, exp;
        for (int i = 0; i < 9; i++) begin
            reset = (i == 0);
            din   = d[i];
            sb.push_back((i == 0) ? model_sum(din) : e[i]);
            #8;
            got = dout;
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL step[%0d]: got %h expected %h", i, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_held();
        logic        r [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [63:0] d [7] = '{64'h5, 64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h66};
        logic [63:0] e [7] = '{64'h0, 64'h11, 64'h22, 64'h33, 64'h44, 64'h99, 64'hFF};
        logic [63:0] got, exp;
        for (int i = 0; i < 7; i++) begin
            reset = r[i];
            din   = d[i];
            sb.push_back((i == 0) ? model_sum(din) : e[i]);
            #8;
            got = dout;
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_held[%0d]: got %h expected %h", i, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [63:0] got, exp;
        for (int i = 0; i < 1025; i++) begin
            reset = (i == 0) || ($urandom_range(0, 63) == 0);
            din   = {$urandom, $urandom};
            sb.push_back(model_sum(din));
            #8;
            got = dout;
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        din   = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_ramp();
        test_wrap();
        test_mid_reset();
        test_step();
        test_reset_held();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
